// File: rtl/demux_buffer.sv
`default_nettype none
// ============================================================================
// Module   : demux_buffer
// Purpose  : Routes the 2:1 mux output stream back into two independent
//            per-lane circular FIFOs, chosen by the selector that built each
//            word. Each lane is drained by its own pop request through a
//            registered output. Per-lane full/empty flags are provided, along
//            with a sticky overflow flag for pushes dropped on a full lane.
// Ports    : clk, reset_L (async, active-low)
//            data_in/valid_in/selector  - incoming word and its destination lane
//            pop0/pop1                  - per-lane read requests
//            data_outN/valid_outN       - registered popped word, one-cycle strobe
//            emptyN/fullN               - decoded from registered occupancy
//            overflow_err               - sticky drop indicator
// Revision : 1.0 - initial release
// ============================================================================
module demux_buffer #(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  selector,
  input  logic                  pop0,
  input  logic                  pop1,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic                  valid_out0,
  output logic                  valid_out1,
  output logic                  empty0,
  output logic                  empty1,
  output logic                  full0,
  output logic                  full1,
  output logic                  overflow_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [1:0]                 w_push_req;
  logic [1:0]                 w_pop_req;
  logic [1:0]                 w_drop;
  logic [1:0]                 w_empty;
  logic [1:0]                 w_full;
  logic [1:0]                 w_vout;
  logic [1:0][DATA_WIDTH-1:0] w_dout;
  logic                       r_overflow;

  assign w_push_req = {valid_in & selector, valid_in & ~selector};
  assign w_pop_req  = {pop1, pop0};

  for (genvar i = 0; i < 2; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr;
    logic [PW-1:0]         r_rd;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_vout;
    logic                  w_do_pop;
    logic                  w_do_push;

    assign w_empty[i] = (r_cnt == '0);
    assign w_full[i]  = (r_cnt == CW'(DEPTH));

    // A full lane is never empty, so a pop on it always frees the slot the
    // concurrent push needs. An empty lane has no bypass: the pop is ignored.
    assign w_do_pop  = w_pop_req[i] & ~w_empty[i];
    assign w_do_push = w_push_req[i] & (~w_full[i] | w_do_pop);
    assign w_drop[i] = w_push_req[i] & w_full[i] & ~w_pop_req[i];

    // Storage is deliberately left out of reset; the pointers make stale
    // contents unreachable.
    always_ff @(posedge clk) begin
      if (w_do_push) begin
        r_mem[r_wr] <= data_in;
      end
    end

    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        r_wr   <= '0;
        r_rd   <= '0;
        r_cnt  <= '0;
        r_dout <= '0;
        r_vout <= 1'b0;
      end else begin
        r_vout <= w_do_pop;
        if (w_do_push) begin
          r_wr <= r_wr + PW'(1);
        end
        if (w_do_pop) begin
          r_dout <= r_mem[r_rd];
          r_rd   <= r_rd + PW'(1);
        end
        case ({w_do_push, w_do_pop})
          2'b10:   r_cnt <= r_cnt + CW'(1);
          2'b01:   r_cnt <= r_cnt - CW'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    assign w_dout[i] = r_dout;
    assign w_vout[i] = r_vout;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_overflow <= 1'b0;
    end else if (|w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign data_out0    = w_dout[0];
  assign data_out1    = w_dout[1];
  assign valid_out0   = w_vout[0];
  assign valid_out1   = w_vout[1];
  assign empty0       = w_empty[0];
  assign empty1       = w_empty[1];
  assign full0        = w_full[0];
  assign full1        = w_full[1];
  assign overflow_err = r_overflow;

endmodule
`default_nettype wire
